// File: rtl/bitmap_index_serializer_if.sv
// ============================================================================
// Module   : bitmap_index_serializer_if
// Purpose  : Bitmap input stream and index output stream of the serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bitmap_index_serializer_if #(
   parameter int W     = 16,
   parameter int TAG_W = 8
);
   localparam int c_idx_w = $clog2(W);

   logic               in_valid;
   logic               in_ready;
   logic [W-1:0]       in_bitmap;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [c_idx_w-1:0] out_index;
   logic [TAG_W-1:0]   out_tag;
   logic               out_last;
   logic               busy;

   // Producer of bitmaps and consumer of indices
   modport master (
      output in_valid, in_bitmap, in_tag, out_ready,
      input  in_ready, out_valid, out_index, out_tag, out_last, busy
   );

   modport slave (
      input  in_valid, in_bitmap, in_tag, out_ready,
      output in_ready, out_valid, out_index, out_tag, out_last, busy
   );
endinterface

`default_nettype wire

// File: rtl/bitmap_index_serializer.sv
// ============================================================================
// Module   : bitmap_index_serializer
// Purpose  : Emits one index per set bit of an accepted bitmap, lowest first.
//            Optional: BITMAP_INDEX_SERIALIZER_PREFETCH_EN accepts the next
//            bitmap in the same cycle the last index is consumed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_encoder #(
   parameter int W = 16
) (
   input  wire logic [W-1:0]         req,
   output logic                      valid,
   output logic [$clog2(W)-1:0]      index
);
   localparam int c_idx_w = $clog2(W);

   always_comb begin
      valid = |req;
      index = '0;
      // Descending scan so the lowest set bit is the last to win
      for (int i = W - 1; i >= 0; i--) begin
         if (req[i]) begin
            index = i[c_idx_w-1:0];
         end
      end
   end
endmodule

module bitmap_index_serializer #(
   parameter int W     = 16,
   parameter int TAG_W = 8
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   bitmap_index_serializer_if.slave   bus
);
   localparam int c_idx_w = $clog2(W);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t             r_state;
   logic [W-1:0]       r_mask;
   logic [TAG_W-1:0]   r_tag;

   logic               w_sel_valid;
   logic [c_idx_w-1:0] w_index;
   logic [W-1:0]       w_rest;
   logic               w_last;
   logic               w_in_fire;

   priority_encoder #(.W(W)) u_pe (
      .req   (r_mask),
      .valid (w_sel_valid),
      .index (w_index)
   );

   always_comb begin
      w_rest          = r_mask;
      w_rest[w_index] = 1'b0;
   end

   // Gated by the encoder so an empty mask never reports a last index
   assign w_last = w_sel_valid && (w_rest == '0);

`ifdef BITMAP_INDEX_SERIALIZER_PREFETCH_EN
   assign bus.in_ready = (r_state == IDLE) || (bus.out_ready && w_last);
`else
   assign bus.in_ready = (r_state == IDLE);
`endif

   assign w_in_fire     = bus.in_valid && bus.in_ready;
   assign bus.out_valid = (r_state == DRAIN);
   assign bus.busy      = (r_state == DRAIN);
   assign bus.out_index = w_index;
   assign bus.out_tag   = r_tag;
   assign bus.out_last  = w_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_mask  <= '0;
         r_tag   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_in_fire && (bus.in_bitmap != '0)) begin
                  r_mask  <= bus.in_bitmap;
                  r_tag   <= bus.in_tag;
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (bus.out_ready) begin
                  if (w_last) begin
`ifdef BITMAP_INDEX_SERIALIZER_PREFETCH_EN
                     if (w_in_fire) begin
                        r_mask  <= bus.in_bitmap;
                        r_tag   <= bus.in_tag;
                        r_state <= (bus.in_bitmap != '0) ? DRAIN : IDLE;
                     end else begin
                        r_mask  <= '0;
                        r_state <= IDLE;
                     end
`else
                     r_mask  <= '0;
                     r_state <= IDLE;
`endif
                  end else begin
                     r_mask <= w_rest;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_mask  <= '0;
            end
         endcase
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_bitmap_index_serializer.sv
// ============================================================================
// Module   : tb_bitmap_index_serializer
// Purpose  : Directed self-checking bench for bitmap_index_serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bitmap_index_serializer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   bitmap_index_serializer_if #(.W(16), .TAG_W(8)) bus ();

   bitmap_index_serializer #(.W(16), .TAG_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Presents one bitmap while the DUT is idle; returns just after acceptance.
   task automatic send(input logic [15:0] bm, input logic [7:0] tg);
      bus.in_valid  = 1'b1;
      bus.in_bitmap = bm;
      bus.in_tag    = tg;
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.in_bitmap = 'x;
      bus.in_tag    = 'x;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_vec++; if (bus.out_index !== 4'd0) begin n_err++; $display("FAIL reset_out_index: got %0d want 0", bus.out_index); end
      n_vec++; if (bus.out_tag !== 8'h00) begin n_err++; $display("FAIL reset_out_tag: got %h want 00", bus.out_tag); end
      n_vec++; if (bus.out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
   endtask

   task automatic test_sparse();
      int exp_idx[4] = '{0, 5, 10, 15};
      bus.out_ready = 1'b1;
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL sparse_accept: in_ready got %b want 1", bus.in_ready); end
      send(16'h8421, 8'h5A);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL sparse_valid[%0d]: got %b want 1", k, bus.out_valid); end
         n_vec++; if (bus.out_index !== 4'(exp_idx[k])) begin n_err++; $display("FAIL sparse_index[%0d]: got %0d want %0d", k, bus.out_index, exp_idx[k]); end
         n_vec++; if (bus.out_tag !== 8'h5A) begin n_err++; $display("FAIL sparse_tag[%0d]: got %h want 5a", k, bus.out_tag); end
         n_vec++; if (bus.out_last !== (k == 3)) begin n_err++; $display("FAIL sparse_last[%0d]: got %b want %b", k, bus.out_last, (k == 3)); end
         n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL sparse_busy[%0d]: got %b want 1", k, bus.busy); end
      end
      @(negedge clk);
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL sparse_idle_valid: got %b want 0", bus.out_valid); end
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL sparse_idle_ready: got %b want 1", bus.in_ready); end
   endtask

   task automatic test_zero();
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL zero_accept: in_ready got %b want 1", bus.in_ready); end
      send(16'h0000, 8'h33);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL zero_valid[%0d]: got %b want 0", k, bus.out_valid); end
         n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL zero_busy[%0d]: got %b want 0", k, bus.busy); end
      end
   endtask

   task automatic test_backpressure();
      logic rdy_seq[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int   exp_idx[5]  = '{1, 1, 1, 2, 2};
      logic exp_last[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      bus.out_ready = 1'b0;
      send(16'h0006, 8'hC3);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         bus.out_ready = rdy_seq[k];
         n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", k, bus.out_valid); end
         n_vec++; if (bus.out_index !== 4'(exp_idx[k])) begin n_err++; $display("FAIL bp_index[%0d]: got %0d want %0d", k, bus.out_index, exp_idx[k]); end
         n_vec++; if (bus.out_last !== exp_last[k]) begin n_err++; $display("FAIL bp_last[%0d]: got %b want %b", k, bus.out_last, exp_last[k]); end
         n_vec++; if (bus.out_tag !== 8'hC3) begin n_err++; $display("FAIL bp_tag[%0d]: got %h want c3", k, bus.out_tag); end
      end
      @(negedge clk);
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle_valid: got %b want 0", bus.out_valid); end
      bus.out_ready = 1'b1;
   endtask

   task automatic test_all_ones();
      bus.out_ready = 1'b1;
      send(16'hFFFF, 8'hA5);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         n_vec++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL ones_busy[%0d]: busy %b valid %b want 1 1", k, bus.busy, bus.out_valid); end
         n_vec++; if (bus.out_index !== 4'(k)) begin n_err++; $display("FAIL ones_index[%0d]: got %0d want %0d", k, bus.out_index, k); end
         n_vec++; if (bus.out_last !== (k == 15)) begin n_err++; $display("FAIL ones_last[%0d]: got %b want %b", k, bus.out_last, (k == 15)); end
      end
      @(negedge clk);
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ones_idle_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_msb_only();
      send(16'h8000, 8'h11);
      @(negedge clk);
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_index !== 4'd15) begin n_err++; $display("FAIL msb_index: valid %b index %0d want 1 15", bus.out_valid, bus.out_index); end
      n_vec++; if (bus.out_last !== 1'b1) begin n_err++; $display("FAIL msb_last: got %b want 1", bus.out_last); end
      @(negedge clk);
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL msb_idle_valid: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_back_to_back();
      int   n_cyc;
      logic e_val[4];
      int   e_idx[4];
      logic [7:0] e_tag[4];
      logic e_last[4];
      logic e_rdy[4];
      logic acc;
`ifdef BITMAP_INDEX_SERIALIZER_PREFETCH_EN
      n_cyc  = 3;
      e_val  = '{1'b1, 1'b1, 1'b1, 1'b0};
      e_idx  = '{0, 1, 4, 0};
      e_tag  = '{8'd1, 8'd1, 8'd2, 8'd0};
      e_last = '{1'b0, 1'b1, 1'b1, 1'b0};
      e_rdy  = '{1'b0, 1'b1, 1'b1, 1'b0};
`else
      n_cyc  = 4;
      e_val  = '{1'b1, 1'b1, 1'b0, 1'b1};
      e_idx  = '{0, 1, 0, 4};
      e_tag  = '{8'd1, 8'd1, 8'd0, 8'd2};
      e_last = '{1'b0, 1'b1, 1'b0, 1'b1};
      e_rdy  = '{1'b0, 1'b0, 1'b1, 1'b0};
`endif
      bus.out_ready = 1'b1;
      send(16'h0003, 8'd1);
      bus.in_valid  = 1'b1;
      bus.in_bitmap = 16'h0010;
      bus.in_tag    = 8'd2;
      for (int k = 0; k < n_cyc; k++) begin
         @(negedge clk);
         n_vec++; if (bus.out_valid !== e_val[k]) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, bus.out_valid, e_val[k]); end
         n_vec++; if (bus.in_ready !== e_rdy[k]) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b want %b", k, bus.in_ready, e_rdy[k]); end
         n_vec++; if (bus.out_last !== e_last[k]) begin n_err++; $display("FAIL b2b_last[%0d]: got %b want %b", k, bus.out_last, e_last[k]); end
         if (e_val[k]) begin
            n_vec++; if (bus.out_index !== 4'(e_idx[k]) || bus.out_tag !== e_tag[k]) begin n_err++; $display("FAIL b2b_index_tag[%0d]: got %0d/%h want %0d/%h", k, bus.out_index, bus.out_tag, e_idx[k], e_tag[k]); end
         end
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            bus.in_valid  = 1'b0;
            bus.in_bitmap = 'x;
            bus.in_tag    = 'x;
         end
      end
      @(negedge clk);
      n_vec++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: valid %b busy %b want 0 0", bus.out_valid, bus.busy); end
      n_vec++; if (bus.in_valid !== 1'b0) begin n_err++; $display("FAIL b2b_second_accepted: in_valid still %b want 0", bus.in_valid); end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset_mid_drain();
      bus.out_ready = 1'b1;
      send(16'hFFFF, 8'h77);
      @(negedge clk);
      @(negedge clk);
      n_vec++; if (bus.out_index !== 4'd1) begin n_err++; $display("FAIL mid_pre_index: got %0d want 1", bus.out_index); end
      #2 rst = 1'b1;
      #1;
      n_vec++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ctrl: valid %b busy %b in_ready %b want 0 0 1", bus.out_valid, bus.busy, bus.in_ready); end
      n_vec++; if (bus.out_index !== 4'd0 || bus.out_tag !== 8'h00 || bus.out_last !== 1'b0) begin n_err++; $display("FAIL mid_rst_data: index %0d tag %h last %b want 0 00 0", bus.out_index, bus.out_tag, bus.out_last); end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_post_valid[%0d]: got %b want 0", k, bus.out_valid); end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_bitmap = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      test_reset();
      test_sparse();
      test_zero();
      test_backpressure();
      test_all_ones();
      test_msb_only();
      test_back_to_back();
      test_reset_mid_drain();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/bitmap_index_serializer.md
Name: bitmap_index_serializer

Overview:
- Accepts a W-bit request bitmap (e.g. per-slot hash-hit flags) plus a tag via valid/ready.
- Emits one index per set bit, lowest index first, over a valid/ready output stream.
- Clears each bit as its index is consumed.
- Sits directly downstream of the bitmap producer. Uses the existing priority_encoder as its lowest-set-bit selector and feeds the per-index match/fetch stage.

Parameters:
- W, 16, bitmap width; power of two, >= 2.
- TAG_W, 8, width of the opaque tag carried with each bitmap.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  bitmap/tag present.
- in_ready  output  1  block can accept a bitmap this cycle.
- in_bitmap  input  W  request bitmap.
- in_tag  input  TAG_W  tag for the bitmap.
- out_valid  output  1  index present.
- out_ready  input  1  consumer accepts the index.
- out_index  output  $clog2(W)  lowest set bit of the remaining mask.
- out_tag  output  TAG_W  tag of the bitmap being drained.
- out_last  output  1  this index is the final set bit of its bitmap.
- busy  output  1  high in DRAIN state.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous, active-high.
- Registers: state, mask_q[W-1:0], tag_q[TAG_W-1:0]. Outputs are combinational from these registers only; there is no combinational path from in_* to out_*.
- Reset values: state=IDLE, mask_q=0, tag_q=0. Resulting outputs: in_ready=1, out_valid=0, out_index=0, out_tag=0, out_last=0, busy=0.
- Reset mid-drain: the remaining mask is discarded and no further index is emitted.
- Lowest-set-bit selection: priority_encoder instance on mask_q (W, valid, index). Its index drives out_index.
- out_last = (mask_q with the selected bit cleared) == 0.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid and a non-zero in_bitmap: load mask_q and tag_q, go to DRAIN.
  - On in_valid and in_bitmap==0: the handshake completes, the bitmap is dropped, there is no output, and the state stays IDLE.
- State DRAIN:
  - out_valid=1, busy=1, in_ready=0 (see Optional Feature for the exception).
  - out_valid, out_index, out_tag and out_last stay stable while out_ready=0.
  - On out_ready: clear the selected bit in mask_q.
  - If out_last: go to IDLE and set mask_q=0.
- Latency: first index appears the cycle after acceptance. Then one index per cycle while out_ready=1. A bitmap with N set bits takes N output cycles.
- Boundaries:
  - All-ones bitmap: W indices 0..W-1, out_last only on W-1.
  - Bit W-1 only: single index W-1, out_last=1.
  - in_valid while in_ready=0: ignored; the upstream must hold the bitmap.
  - X on in_bitmap while in_valid=0 must not propagate into any register.

Optional Feature:
- Macro: BITMAP_INDEX_SERIALIZER_PREFETCH_EN.
- When defined, in DRAIN: in_ready = out_ready & out_last.
  - On a same-cycle input handshake, load the new mask_q and tag_q directly.
  - If the new bitmap is non-zero, stay in DRAIN; if it is zero, go to IDLE.
  - Back-to-back bitmaps then stream with no bubble.
  - in_ready now depends combinationally on out_ready.
- When undefined, in DRAIN: in_ready=0. One idle cycle (in_ready=1, out_valid=0) separates successive bitmaps.

Test Plan:
1. Reset, then idle → in_ready=1, out_valid=0, busy=0. Assert rst asynchronously mid-drain → all outputs return to reset values in the same cycle.
2. in_bitmap=16'h8421, tag=8'h5A, out_ready=1 → next four cycles emit indices 0,5,10,15 with tag 5A. out_last=1 only on 15; IDLE afterwards.
3. in_bitmap=16'h0000 with in_valid=1 → accepted (in_ready=1), no out_valid ever, state stays IDLE.
4. in_bitmap=16'h0006, out_ready toggling 0,0,1,0,1 → index 1 held stable for two cycles, then index 1 consumed, index 2 held one cycle, then consumed with out_last=1.
5. in_bitmap=16'hFFFF, out_ready=1 → 16 consecutive indices 0..15, busy high 16 cycles, out_last on index 15 only.
6. Two bitmaps 16'h0003 (tag 1) then 16'h0010 (tag 2) back-to-back, out_ready=1:
   - Without macro: indices 0,1, one bubble cycle, then 4.
   - With BITMAP_INDEX_SERIALIZER_PREFETCH_EN: indices 0,1,4 on consecutive cycles, tags 1,1,2.
